// File: rtl/rps_pkg.sv
// Shared definitions for the stone-paper-scissors round controller:
// move encodings, judge result codes and the round controller states.
package rps_pkg;

    // Move switch encodings
    localparam logic [1:0] MV_STONE    = 2'b00;
    localparam logic [1:0] MV_PAPER    = 2'b01;
    localparam logic [1:0] MV_SCISSORS = 2'b10;
    localparam logic [1:0] MV_INVALID  = 2'b11;

    // Result codes returned by the combinational judge
    localparam logic [7:0] RES_TIE = 8'd0;
    localparam logic [7:0] RES_P1  = 8'd49;
    localparam logic [7:0] RES_P2  = 8'd50;
    localparam logic [7:0] RES_INV = 8'd63;

    // Round controller states
    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        JUDGE = 2'd1,
        SHOW  = 2'd2,
        OVER  = 2'd3
    } state_t;

endpackage

// File: rtl/rps_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A level rising on din produces a one-cycle pulse on rise three clock
// edges later.
module rps_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronise the asynchronous level, then flag its 0->1 transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, so this forms a real shift chain.
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round controller in front of the stone-paper-scissors judge: locks both
// players' moves, captures the judge's verdict, holds it for display,
// keeps the score and declares the match winner.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned HOLD_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] p1_move,
    input  logic       p1_commit,
    input  logic [1:0] p2_move,
    input  logic       p2_commit,
    input  logic       new_match,
    input  logic [7:0] judge_result,
    output logic [1:0] judge_p1,
    output logic [1:0] judge_p2,
    output logic [7:0] disp,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       round_done,
    output logic       void_round,
    output logic [1:0] locked,
    output logic       match_over
);

    localparam logic [3:0]        WIN       = 4'(WIN_SCORE);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic p1_rise;
    logic p2_rise;
    logic match_rise;

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [1:0]        judge_p1_n, judge_p2_n, locked_n;
    logic [7:0]        disp_n;
    logic [3:0]        score_p1_n, score_p2_n;
    logic              round_done_n, void_round_n;

    rps_sync_edge u_sync_p1 (.clk(clk), .rst(rst), .din(p1_commit), .rise(p1_rise));
    rps_sync_edge u_sync_p2 (.clk(clk), .rst(rst), .din(p2_commit), .rise(p2_rise));
    rps_sync_edge u_sync_nm (.clk(clk), .rst(rst), .din(new_match), .rise(match_rise));

    // Next-state and next-output decode; new_match overrides everything
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_n      = state;
        hold_n       = hold;
        judge_p1_n   = judge_p1;
        judge_p2_n   = judge_p2;
        locked_n     = locked;
        disp_n       = disp;
        score_p1_n   = score_p1;
        score_p2_n   = score_p2;
        round_done_n = 1'b0;
        void_round_n = 1'b0;

        case (state)
            WAIT: begin
                disp_n = RES_TIE;
                if (p1_rise && !locked[0]) begin
                    judge_p1_n  = p1_move;
                    locked_n[0] = 1'b1;
                end
                if (p2_rise && !locked[1]) begin
                    judge_p2_n  = p2_move;
                    locked_n[1] = 1'b1;
                end
                if (locked == 2'b11) begin
                    state_n = JUDGE;
                end
            end
            JUDGE: begin
                disp_n       = judge_result;
                round_done_n = 1'b1;
                case (judge_result)
                    RES_TIE: ;
                    RES_P1:  if (score_p1 < WIN) score_p1_n = score_p1 + 4'd1;
                    RES_P2:  if (score_p2 < WIN) score_p2_n = score_p2 + 4'd1;
                    default: void_round_n = 1'b1;
                endcase
                hold_n  = HOLD_LOAD;
                state_n = SHOW;
            end
            SHOW: begin
                if (hold == '0) begin
                    locked_n = 2'b00;
                    if (score_p1 == WIN || score_p2 == WIN) begin
                        state_n = OVER;
                        disp_n  = (score_p1 == WIN) ? RES_P1 : RES_P2;
                    end else begin
                        state_n = WAIT;
                        disp_n  = RES_TIE;
                    end
                end else begin
                    hold_n = hold - HOLD_W'(1);
                end
            end
            OVER: begin
                disp_n = (score_p1 == WIN) ? RES_P1 : RES_P2;
            end
            default: state_n = WAIT;
        endcase

        if (match_rise) begin
            state_n      = WAIT;
            score_p1_n   = 4'd0;
            score_p2_n   = 4'd0;
            locked_n     = 2'b00;
            disp_n       = RES_TIE;
            hold_n       = '0;
            round_done_n = 1'b0;
            void_round_n = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT;
            hold       <= '0;
            judge_p1   <= 2'b00;
            judge_p2   <= 2'b00;
            locked     <= 2'b00;
            disp       <= 8'd0;
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            round_done <= 1'b0;
            void_round <= 1'b0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            judge_p1   <= judge_p1_n;
            judge_p2   <= judge_p2_n;
            locked     <= locked_n;
            disp       <= disp_n;
            score_p1   <= score_p1_n;
            score_p2   <= score_p2_n;
            round_done <= round_done_n;
            void_round <= void_round_n;
        end
    end

    assign match_over = (state == OVER);

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Self-checking bench for rps_round_ctrl: hand sequences for latency,
// ignore rules, match end, restart priority and reset, plus a table of rounds.
module tb_rps_round_ctrl;
    import rps_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] p1_move, p2_move;
    logic       p1_commit, p2_commit, new_match;
    logic [7:0] judge_result;
    logic [1:0] judge_p1, judge_p2, locked;
    logic [7:0] disp;
    logic [3:0] score_p1, score_p2;
    logic       round_done, void_round, match_over;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic [1:0] p1m;
        logic [1:0] p2m;
        logic [7:0] res;
        logic       simul;
        logic [7:0] exp_disp;
        logic [3:0] exp_s1;
        logic [3:0] exp_s2;
        logic       exp_void;
        logic [7:0] exp_after;
        logic       exp_over;
    } vec_t;

    vec_t vecs [6];

    rps_round_ctrl #(.WIN_SCORE(3), .HOLD_CYCLES(16), .HOLD_W(24)) dut (
        .clk(clk), .rst(rst),
        .p1_move(p1_move), .p1_commit(p1_commit),
        .p2_move(p2_move), .p2_commit(p2_commit),
        .new_match(new_match), .judge_result(judge_result),
        .judge_p1(judge_p1), .judge_p2(judge_p2), .disp(disp),
        .score_p1(score_p1), .score_p2(score_p2),
        .round_done(round_done), .void_round(void_round),
        .locked(locked), .match_over(match_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_locked(input logic [1:0] exp, input string name);
        for (int i = 0; i < 12; i++) begin
            if (locked == exp) break;
            tick();
        end
        check(name, 32'(locked), 32'(exp));
    endtask

    // Lock both moves and check round_done arrives exactly two cycles after the second lock
    task automatic start_round(input logic [1:0] m1, input logic [1:0] m2,
                               input logic [7:0] res, input logic simul);
        judge_result = res;
        p1_move      = m1;
        p2_move      = m2;
        if (simul) begin
            p1_commit = 1'b1;
            p2_commit = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (locked != 2'b00) break;
                tick();
            end
            check("simul_lock", 32'(locked), 32'(2'b11));
            p1_commit = 1'b0;
            p2_commit = 1'b0;
        end else begin
            p1_commit = 1'b1;
            wait_locked(2'b01, "p1_lock");
            p1_commit = 1'b0;
            p2_commit = 1'b1;
            wait_locked(2'b11, "p2_lock");
            p2_commit = 1'b0;
        end
        tick();
        check("round_done_early", 32'(round_done), 32'(1'b0));
        tick();
        check("round_done_pulse", 32'(round_done), 32'(1'b1));
    endtask

    // Called at the round_done sample; walks through the 16-cycle hold
    task automatic finish_hold(input logic [7:0] exp_disp, input logic [7:0] exp_after,
                               input logic exp_over);
        tick();
        check("round_done_one_cycle", 32'(round_done), 32'(1'b0));
        check("void_one_cycle", 32'(void_round), 32'(1'b0));
        tick(14);
        check("disp_held", 32'(disp), 32'(exp_disp));
        tick();
        check("disp_after_hold", 32'(disp), 32'(exp_after));
        check("locked_after_hold", 32'(locked), 32'(2'b00));
        check("match_over_after_hold", 32'(match_over), 32'(exp_over));
    endtask

    initial begin
        vecs[0] = '{2'b11, 2'b01, 8'd63, 1'b1, 8'd63, 4'd1, 4'd0, 1'b1, 8'd0,  1'b0};
        vecs[1] = '{2'b00, 2'b00, 8'd0,  1'b0, 8'd0,  4'd1, 4'd0, 1'b0, 8'd0,  1'b0};
        vecs[2] = '{2'b01, 2'b10, 8'd7,  1'b0, 8'd7,  4'd1, 4'd0, 1'b1, 8'd0,  1'b0};
        vecs[3] = '{2'b10, 2'b01, 8'd50, 1'b1, 8'd50, 4'd1, 4'd1, 1'b0, 8'd0,  1'b0};
        vecs[4] = '{2'b00, 2'b01, 8'd50, 1'b0, 8'd50, 4'd1, 4'd2, 1'b0, 8'd0,  1'b0};
        vecs[5] = '{2'b01, 2'b10, 8'd50, 1'b0, 8'd50, 4'd1, 4'd3, 1'b0, 8'd50, 1'b1};

        rst = 1'b1;
        p1_move = 2'b00; p2_move = 2'b00;
        p1_commit = 1'b0; p2_commit = 1'b0; new_match = 1'b0;
        judge_result = 8'd0;
        tick(2);
        check("rst_disp", 32'(disp), 32'd0);
        check("rst_scores", 32'({score_p1, score_p2}), 32'd0);
        check("rst_judge", 32'({judge_p1, judge_p2}), 32'd0);
        check("rst_flags", 32'({locked, round_done, void_round, match_over}), 32'd0);
        rst = 1'b0;
        tick(2);

        // Basic round with lock latency and re-commit ignore rule
        judge_result = 8'd49;
        p1_move = MV_PAPER;
        p1_commit = 1'b1;
        tick(3);
        check("lock_latency_early", 32'(locked), 32'(2'b00));
        tick();
        check("lock_latency", 32'(locked), 32'(2'b01));
        p1_commit = 1'b0;
        tick(3);
        p1_move = MV_SCISSORS;
        p1_commit = 1'b1;
        tick(6);
        check("relock_ignored", 32'(judge_p1), 32'(MV_PAPER));
        check("relock_locked", 32'(locked), 32'(2'b01));
        p1_commit = 1'b0;
        p2_move = MV_STONE;
        p2_commit = 1'b1;
        wait_locked(2'b11, "basic_p2_lock");
        p2_commit = 1'b0;
        tick();
        check("basic_rd_early", 32'(round_done), 32'(1'b0));
        tick();
        check("basic_rd", 32'(round_done), 32'(1'b1));
        check("basic_disp", 32'(disp), 32'd49);
        check("basic_score_p1", 32'(score_p1), 32'd1);
        check("basic_score_p2", 32'(score_p2), 32'd0);
        check("basic_judge_p2", 32'(judge_p2), 32'(MV_STONE));
        check("basic_void", 32'(void_round), 32'(1'b0));
        // Commit pressed while the result is on show must be discarded
        tick();
        p1_commit = 1'b1;
        tick(5);
        p1_commit = 1'b0;
        tick(9);
        check("basic_disp_held", 32'(disp), 32'd49);
        tick();
        check("basic_disp_cleared", 32'(disp), 32'd0);
        check("basic_locked_cleared", 32'(locked), 32'(2'b00));
        tick(6);
        check("show_commit_discarded", 32'(locked), 32'(2'b00));

        // Table of rounds, ending with P2 taking the match
        for (int i = 0; i < 6; i++) begin
            start_round(vecs[i].p1m, vecs[i].p2m, vecs[i].res, vecs[i].simul);
            check($sformatf("v%0d_judge_p1", i), 32'(judge_p1), 32'(vecs[i].p1m));
            check($sformatf("v%0d_judge_p2", i), 32'(judge_p2), 32'(vecs[i].p2m));
            check($sformatf("v%0d_disp", i), 32'(disp), 32'(vecs[i].exp_disp));
            check($sformatf("v%0d_void", i), 32'(void_round), 32'(vecs[i].exp_void));
            check($sformatf("v%0d_score_p1", i), 32'(score_p1), 32'(vecs[i].exp_s1));
            check($sformatf("v%0d_score_p2", i), 32'(score_p2), 32'(vecs[i].exp_s2));
            finish_hold(vecs[i].exp_disp, vecs[i].exp_after, vecs[i].exp_over);
        end

        // Commits in OVER are ignored
        p1_move = MV_STONE; p2_move = MV_STONE;
        p1_commit = 1'b1; p2_commit = 1'b1;
        tick(8);
        check("over_locked", 32'(locked), 32'(2'b00));
        check("over_match_over", 32'(match_over), 32'(1'b1));
        check("over_disp", 32'(disp), 32'd50);
        check("over_score_p2", 32'(score_p2), 32'd3);
        check("over_judge_p1", 32'(judge_p1), 32'(2'b01));
        p1_commit = 1'b0; p2_commit = 1'b0;
        tick(3);

        // Restart from OVER
        new_match = 1'b1;
        tick(4);
        check("restart_match_over", 32'(match_over), 32'(1'b0));
        check("restart_scores", 32'({score_p1, score_p2}), 32'd0);
        check("restart_disp", 32'(disp), 32'd0);
        new_match = 1'b0;
        tick(3);

        // new_match coinciding with hold expiry at the winning score
        for (int r = 1; r <= 2; r++) begin
            start_round(MV_STONE, MV_PAPER, RES_P2, 1'b0);
            check($sformatf("p2_run%0d_score", r), 32'(score_p2), 32'(r));
            finish_hold(RES_P2, RES_TIE, 1'b0);
        end
        start_round(MV_STONE, MV_PAPER, RES_P2, 1'b0);
        check("prio_score_p2", 32'(score_p2), 32'd3);
        tick(12);
        new_match = 1'b1;
        tick(4);
        check("prio_match_over", 32'(match_over), 32'(1'b0));
        check("prio_scores", 32'({score_p1, score_p2}), 32'd0);
        check("prio_disp", 32'(disp), 32'd0);
        check("prio_locked", 32'(locked), 32'(2'b00));
        tick();
        check("prio_stays_wait", 32'(match_over), 32'(1'b0));
        new_match = 1'b0;
        tick(3);

        // Asynchronous reset in the middle of SHOW
        start_round(MV_SCISSORS, MV_PAPER, RES_P1, 1'b0);
        check("pre_reset_score_p1", 32'(score_p1), 32'd1);
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_disp", 32'(disp), 32'd0);
        check("async_rst_scores", 32'({score_p1, score_p2}), 32'd0);
        check("async_rst_judge", 32'({judge_p1, judge_p2}), 32'd0);
        check("async_rst_flags", 32'({locked, round_done, void_round, match_over}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(20);
        check("post_rst_disp", 32'(disp), 32'd0);
        check("post_rst_flags", 32'({locked, round_done, match_over}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
